// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle between three Wishbone masters (host loader, CPU I-bus, CPU D-bus)
// and the single program-RAM slave port.
//
// Handshake: a master requests by raising cyc and stb (its "valid"). It keeps
// adr/dat/sel/we stable until the beat ends with ack (done) or err (failed),
// which acts as "ready" and is high for exactly the completing cycle. cyc may
// stay high across several beats to keep the bus locked.
//
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system, which drives the mN_*_i and s_*_i side.
interface wb_ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   m0_adr_i, m1_adr_i, m2_adr_i;
  logic [DW-1:0]   m0_dat_i, m1_dat_i, m2_dat_i;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i, m2_sel_i;
  logic            m0_we_i, m1_we_i, m2_we_i;
  logic            m0_cyc_i, m1_cyc_i, m2_cyc_i;
  logic            m0_stb_i, m1_stb_i, m2_stb_i;
  logic [DW-1:0]   m0_dat_o, m1_dat_o, m2_dat_o;
  logic            m0_ack_o, m1_ack_o, m2_ack_o;
  logic            m0_err_o, m1_err_o, m2_err_o;

  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic            s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m2_adr_i, m2_dat_i, m2_sel_i, m2_we_i, m2_cyc_i, m2_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output m2_dat_o, m2_ack_o, m2_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m2_adr_i, m2_dat_i, m2_sel_i, m2_we_i, m2_cyc_i, m2_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  m2_dat_o, m2_ack_o, m2_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Program-RAM arbiter: host loader (m0) has absolute priority, the CPU I-bus
// (m1) and D-bus (m2) share round-robin. Ownership lasts while the owner holds
// cyc. A watchdog aborts any beat left unacknowledged for TIMEOUT cycles.
module wb_ram_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_active_i,
  wb_ram_arbiter_if.slave   bus,
  output logic [1:0]        grant_o,
  output logic              timeout_o,
  output logic [1:0]        state_o
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the last tolerated unacked cycle.
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_cpu_q, last_cpu_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;

  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat;
  logic [DW/8-1:0] own_sel;
  logic            own_we, own_cyc, own_stb;
  logic            in_grant, in_abort;

  // Select the current owner's request signals; nothing when no owner.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (grant_q)
      2'd0: begin
        own_adr = bus.m0_adr_i; own_dat = bus.m0_dat_i; own_sel = bus.m0_sel_i;
        own_we  = bus.m0_we_i;  own_cyc = bus.m0_cyc_i; own_stb = bus.m0_stb_i;
      end
      2'd1: begin
        own_adr = bus.m1_adr_i; own_dat = bus.m1_dat_i; own_sel = bus.m1_sel_i;
        own_we  = bus.m1_we_i;  own_cyc = bus.m1_cyc_i; own_stb = bus.m1_stb_i;
      end
      2'd2: begin
        own_adr = bus.m2_adr_i; own_dat = bus.m2_dat_i; own_sel = bus.m2_sel_i;
        own_we  = bus.m2_we_i;  own_cyc = bus.m2_cyc_i; own_stb = bus.m2_stb_i;
      end
      default: ;
    endcase
  end

  // Arbitration, ownership hold and watchdog next-state logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_cpu_d = last_cpu_q;
    wd_cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i) begin
          grant_d = 2'd0;
          state_d = GRANT;
        end else if (!load_active_i && (bus.m1_cyc_i || bus.m2_cyc_i)) begin
          // On a tie the CPU master that did not own the bus last wins.
          if (bus.m1_cyc_i && (!bus.m2_cyc_i || last_cpu_q == 2'd2)) grant_d = 2'd1;
          else                                                       grant_d = 2'd2;
          last_cpu_d = grant_d;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = 2'd3;
        end else if (TIMEOUT != 0 && own_stb && !bus.s_ack_i && !bus.s_err_i) begin
          if (wd_cnt_q == WD_LAST) state_d  = ABORT;
          else                     wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = 2'd3;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'd3;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      grant_q    <= 2'd3;
      last_cpu_q <= 2'd2;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_cpu_q <= last_cpu_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  assign in_grant = (state_q == GRANT);
  assign in_abort = (state_q == ABORT);

  // Slave side: owner's request; cyc/stb squashed in ABORT and while reset is
  // asserted so an abandoned beat cannot complete.
  assign bus.s_adr_o = own_adr;
  assign bus.s_dat_o = own_dat;
  assign bus.s_sel_o = own_sel;
  assign bus.s_we_o  = own_we;
  assign bus.s_cyc_o = rst_i & in_grant & own_cyc;
  assign bus.s_stb_o = rst_i & in_grant & own_stb;
  assign bus.s_cti_o = 3'b000;
  assign bus.s_bte_o = 2'b00;

  // Master side: only the owner sees slave responses; the watchdog error
  // replaces the slave response during ABORT.
  assign bus.m0_dat_o = (in_grant && grant_q == 2'd0) ? bus.s_dat_i : '0;
  assign bus.m1_dat_o = (in_grant && grant_q == 2'd1) ? bus.s_dat_i : '0;
  assign bus.m2_dat_o = (in_grant && grant_q == 2'd2) ? bus.s_dat_i : '0;
  assign bus.m0_ack_o = rst_i & in_grant & (grant_q == 2'd0) & bus.s_ack_i;
  assign bus.m1_ack_o = rst_i & in_grant & (grant_q == 2'd1) & bus.s_ack_i;
  assign bus.m2_ack_o = rst_i & in_grant & (grant_q == 2'd2) & bus.s_ack_i;
  assign bus.m0_err_o = rst_i & (grant_q == 2'd0) & ((in_grant & bus.s_err_i) | in_abort);
  assign bus.m1_err_o = rst_i & (grant_q == 2'd1) & ((in_grant & bus.s_err_i) | in_abort);
  assign bus.m2_err_o = rst_i & (grant_q == 2'd2) & ((in_grant & bus.s_err_i) | in_abort);

  assign grant_o   = grant_q;
  assign timeout_o = rst_i & in_abort;
  assign state_o   = state_q;
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed master traffic against a small RAM slave,
// a cycle-level ownership model compared every cycle, and literal expectations.
module tb_wb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       load_active = 1'b0;
  logic [1:0] grant, state_dbg;
  logic       timeout;

  wb_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n), .load_active_i(load_active), .bus(bus),
    .grant_o(grant), .timeout_o(timeout), .state_o(state_dbg)
  );

  // Master request arrays, mapped onto the interface.
  logic [AW-1:0] m_adr [3];
  logic [DW-1:0] m_wdat[3];
  logic [3:0]    m_sel [3];
  logic          m_we  [3];
  logic          m_cyc [3];
  logic          m_stb [3];
  logic [DW-1:0] m_rdat[3];
  logic          m_ack [3];
  logic          m_err [3];

  assign bus.m0_adr_i = m_adr[0]; assign bus.m1_adr_i = m_adr[1]; assign bus.m2_adr_i = m_adr[2];
  assign bus.m0_dat_i = m_wdat[0]; assign bus.m1_dat_i = m_wdat[1]; assign bus.m2_dat_i = m_wdat[2];
  assign bus.m0_sel_i = m_sel[0]; assign bus.m1_sel_i = m_sel[1]; assign bus.m2_sel_i = m_sel[2];
  assign bus.m0_we_i  = m_we[0];  assign bus.m1_we_i  = m_we[1];  assign bus.m2_we_i  = m_we[2];
  assign bus.m0_cyc_i = m_cyc[0]; assign bus.m1_cyc_i = m_cyc[1]; assign bus.m2_cyc_i = m_cyc[2];
  assign bus.m0_stb_i = m_stb[0]; assign bus.m1_stb_i = m_stb[1]; assign bus.m2_stb_i = m_stb[2];
  assign m_rdat[0] = bus.m0_dat_o; assign m_rdat[1] = bus.m1_dat_o; assign m_rdat[2] = bus.m2_dat_o;
  assign m_ack[0]  = bus.m0_ack_o; assign m_ack[1]  = bus.m1_ack_o; assign m_ack[2]  = bus.m2_ack_o;
  assign m_err[0]  = bus.m0_err_o; assign m_err[1]  = bus.m1_err_o; assign m_err[2]  = bus.m2_err_o;

  // ---------------- RAM slave ----------------
  logic [DW-1:0] s_rdat = '0;
  logic          s_ack  = 1'b0;
  logic          s_err  = 1'b0;
  assign bus.s_dat_i = s_rdat;
  assign bus.s_ack_i = s_ack;
  assign bus.s_err_i = s_err;

  logic [DW-1:0] ram[16];
  int            ack_lat = 1;      // ack on this strobe cycle of a beat; 0 = never
  bit            slave_auto = 1'b1;
  logic          man_ack = 1'b0;
  logic [DW-1:0] man_dat = '0;
  int            beat_cnt = 0;

  initial for (int i = 0; i < 16; i++) ram[i] = 32'h1000 + i;

  // Responds a little after each edge, once the arbiter outputs have settled.
  always @(posedge clk) begin
    #2;
    if (!slave_auto) begin
      s_ack  = man_ack;
      s_rdat = man_dat;
    end else if (bus.s_cyc_o && bus.s_stb_o) begin
      beat_cnt = s_ack ? 1 : beat_cnt + 1;
      if (ack_lat != 0 && beat_cnt == ack_lat) begin
        s_ack = 1'b1;
        if (bus.s_we_o) begin
          ram[bus.s_adr_o[5:2]] = bus.s_dat_o;
          s_rdat = '0;
        end else begin
          s_rdat = ram[bus.s_adr_o[5:2]];
        end
      end else begin
        s_ack  = 1'b0;
        s_rdat = '0;
      end
    end else begin
      beat_cnt = 0;
      s_ack    = 1'b0;
      s_rdat   = '0;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Ownership model: who owns the RAM, whether the watchdog is firing,
  // and how long the owner has been waiting.
  int mod_owner = 3;   // 0..2, 3 = nobody
  int mod_last  = 2;
  int mod_wait  = 0;
  bit mod_abort = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mod_owner = 3; mod_last = 2; mod_wait = 0; mod_abort = 1'b0;
    end else if (mod_abort) begin
      mod_abort = 1'b0;
      mod_owner = 3;
    end else if (mod_owner == 3) begin
      if (m_cyc[0]) mod_owner = 0;
      else if (!load_active) begin
        if (m_cyc[1] && m_cyc[2]) mod_owner = 3 - mod_last;
        else if (m_cyc[1])        mod_owner = 1;
        else if (m_cyc[2])        mod_owner = 2;
        if (mod_owner != 3) mod_last = mod_owner;
      end
    end else if (!m_cyc[mod_owner]) begin
      mod_owner = 3;
      mod_wait  = 0;
    end else if (m_stb[mod_owner] && !s_ack && !s_err) begin
      mod_wait++;
      if (mod_wait >= TO) begin
        mod_abort = 1'b1;
        mod_wait  = 0;
      end
    end else begin
      mod_wait = 0;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  logic live, busy;
  bit   own_ok;
  int   own;
  always @(negedge clk) begin
    if (chk_en) begin
      live   = rst_n;
      own_ok = (mod_owner < 3);
      own    = own_ok ? mod_owner : 0;
      busy   = live && own_ok && !mod_abort;
      chk("grant_o", grant, mod_owner[1:0]);
      chk("timeout_o", timeout, live && mod_abort);
      chk("s_cyc_o", bus.s_cyc_o, busy && m_cyc[own]);
      chk("s_stb_o", bus.s_stb_o, busy && m_stb[own]);
      chk("s_adr_o", bus.s_adr_o, own_ok ? m_adr[own] : '0);
      chk("s_dat_o", bus.s_dat_o, own_ok ? m_wdat[own] : '0);
      chk("s_sel_o", bus.s_sel_o, own_ok ? m_sel[own] : '0);
      chk("s_we_o", bus.s_we_o, own_ok ? m_we[own] : 1'b0);
      chk("s_cti_bte", {bus.s_cti_o, bus.s_bte_o}, 5'd0);
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("m%0d_ack_o", n), m_ack[n], busy && mod_owner == n && s_ack);
        chk($sformatf("m%0d_err_o", n), m_err[n],
            live && mod_owner == n && (mod_abort || s_err));
        chk($sformatf("m%0d_dat_o", n), m_rdat[n],
            (own_ok && !mod_abort && mod_owner == n) ? s_rdat : '0);
      end
    end
  end

  // Event monitors: ack pulses, watchdog pulses and the grant change log.
  int         ack_cnt[3] = '{0, 0, 0};
  int         to_cnt = 0;
  logic [1:0] last_g = 2'd3;
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 3; n++) if (m_ack[n]) ack_cnt[n]++;
      if (timeout) to_cnt++;
      if (grant != last_g) begin
        got_q.push_back(grant);
        last_g = grant;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat for master n; keeps cyc/stb high afterwards when hold is set.
  task automatic xfer(input int n, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdat, input bit hold,
                      output logic [31:0] rdat, output logic err, output int ncyc);
    bit done;
    m_adr[n] = adr; m_wdat[n] = wdat; m_we[n] = we; m_sel[n] = 4'hF;
    m_cyc[n] = 1'b1; m_stb[n] = 1'b1;
    done = 1'b0; ncyc = 0; rdat = '0; err = 1'b0;
    while (!done && ncyc < 60) begin
      @(negedge clk);
      ncyc++;
      if (m_ack[n]) begin
        rdat = m_rdat[n];
        done = 1'b1;
      end else if (m_err[n]) begin
        err  = 1'b1;
        done = 1'b1;
      end
    end
    chk($sformatf("m%0d_beat_done", n), done, 1'b1);
    tick();
    if (!hold) begin
      m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_active = 1'b0;
    for (int n = 0; n < 3; n++) begin
      m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Compares grant changes logged since index base against exp_q.
  task automatic check_seq(input string tag, input int base);
    chk({tag, "_len"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      chk($sformatf("%s_g%0d", tag, i), got_q[base + i], exp_q[i]);
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] r0, r1, r2;
  logic        e0, e1, e2;
  int          c0, c1, c2, base, abase, tbase;

  initial begin
    for (int n = 0; n < 3; n++) begin
      m_adr[n] = '0; m_wdat[n] = '0; m_sel[n] = '0;
      m_we[n] = 1'b0; m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
    end
    ram[4] = 32'hDEAD_BEEF;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_grant", grant, 2'd3);
    chk("reset_s_cyc", bus.s_cyc_o, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single m1 read, acked on the 2nd strobe cycle.
    ack_lat = 2;
    abase = ack_cnt[1];
    fork
      xfer(1, 1'b0, 32'h10, '0, 1'b0, r1, e1, c1);
      begin
        @(negedge clk); chk("t1_grant_c0", grant, 2'd3);
        @(negedge clk); chk("t1_grant_c1", grant, 2'd1);
      end
    join
    chk("t1_rdat", r1, 32'hDEAD_BEEF);
    chk("t1_err", e1, 1'b0);
    chk("t1_cycles", c1, 3);
    chk("t1_ack_pulses", ack_cnt[1] - abase, 1);
    chk("t1_m2_acks", ack_cnt[2], 0);

    // Round-robin between m1 and m2 after a fresh reset.
    do_reset();
    ack_lat = 1;
    base = got_q.size();
    fork
      for (int i = 0; i < 2; i++) begin
        xfer(1, 1'b0, 32'h14, '0, 1'b0, r1, e1, c1);
        if (i == 0) tick();
      end
      for (int i = 0; i < 2; i++) begin
        xfer(2, 1'b0, 32'h18, '0, 1'b0, r2, e2, c2);
        if (i == 0) tick();
      end
    join
    repeat (3) tick();
    exp_q = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};
    check_seq("t2_rr", base);

    // Host load locks out m2 until load_active and m0 cyc are both low.
    base = got_q.size();
    load_active = 1'b1;
    tick();
    fork
      xfer(2, 1'b0, 32'h4, '0, 1'b0, r2, e2, c2);
      for (int i = 0; i < 4; i++) begin
        xfer(0, 1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, r0, e0, c0);
        if (i < 3) tick();
        else load_active = 1'b0;
      end
    join
    repeat (3) tick();
    exp_q = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3};
    check_seq("t3_load", base);
    chk("t3_m2_rdat", r2, 32'hA1);
    chk("t3_ram3", ram[3], 32'hA3);

    // m0 waits for m2's locked 3-beat cycle.
    ack_lat = 2;
    base = got_q.size();
    abase = ack_cnt[2];
    fork
      begin
        xfer(2, 1'b1, 32'h20, 32'hB0, 1'b1, r2, e2, c2);
        xfer(2, 1'b1, 32'h24, 32'hB1, 1'b1, r2, e2, c2);
        xfer(2, 1'b1, 32'h28, 32'hB2, 1'b0, r2, e2, c2);
      end
      begin
        repeat (2) tick();
        xfer(0, 1'b0, 32'h20, '0, 1'b0, r0, e0, c0);
      end
    join
    repeat (3) tick();
    exp_q = '{2'd2, 2'd3, 2'd0, 2'd3};
    check_seq("t4_lock", base);
    chk("t4_m2_acks", ack_cnt[2] - abase, 3);
    chk("t4_m0_rdat", r0, 32'hB0);
    chk("t4_ram10", ram[10], 32'hB2);

    // Watchdog: never acked -> abort; acked on the 4th cycle -> no abort.
    ack_lat = 0;
    tbase = to_cnt;
    xfer(1, 1'b0, 32'h10, '0, 1'b0, r1, e1, c1);
    chk("t5_abort_err", e1, 1'b1);
    chk("t5_abort_cycles", c1, 6);
    chk("t5_timeout_pulses", to_cnt - tbase, 1);
    tick();
    ack_lat = 4;
    xfer(1, 1'b0, 32'h10, '0, 1'b0, r1, e1, c1);
    chk("t5_late_err", e1, 1'b0);
    chk("t5_late_cycles", c1, 5);
    chk("t5_late_rdat", r1, 32'hDEAD_BEEF);
    chk("t5_late_timeouts", to_cnt - tbase, 1);
    tick();

    // Reset in the middle of a beat whose ack is arriving.
    slave_auto = 1'b0;
    man_ack = 1'b0;
    m_adr[1] = 32'h10; m_we[1] = 1'b0; m_sel[1] = 4'hF;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    repeat (2) tick();
    man_ack = 1'b1;
    man_dat = 32'h5A5A_5A5A;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_ack_in_reset", m_ack[1], 1'b0);
    tick();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    man_ack = 1'b0;
    man_dat = '0;
    @(negedge clk);
    chk("t6_grant_after", grant, 2'd3);
    chk("t6_err_after", m_err[1], 1'b0);
    chk("t6_cyc_after", bus.s_cyc_o, 1'b0);
    tick();
    slave_auto = 1'b1;
    ack_lat = 1;
    rst_n = 1'b1;
    base = got_q.size();
    fork
      xfer(1, 1'b0, 32'h14, '0, 1'b0, r1, e1, c1);
      xfer(2, 1'b0, 32'h18, '0, 1'b0, r2, e2, c2);
    join
    repeat (3) tick();
    exp_q = '{2'd1, 2'd3, 2'd2, 2'd3};
    check_seq("t6_tie", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
